// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-ported memory bus with a response watchdog.
// Optional round-robin tie-breaking via `MEM_ARBITER_RR_EN; default is fixed data-over-fetch priority.
module mem_arbiter #(
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic        clk,
   input  logic        res,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_valid,
   output logic [31:0] instr_read,
   input  logic        data_req,
   input  logic [31:0] data_addr,
   input  logic        data_write_enable,
   input  logic [31:0] data_write,
   input  logic [3:0]  data_be,
   output logic        data_valid,
   output logic [31:0] data_read,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic        bus_error
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_I = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;
   localparam int CNT_W = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

   logic [1:0]       r_state;
   logic             r_mem_req;
   logic [31:0]      r_mem_addr;
   logic             r_mem_we;
   logic [31:0]      r_mem_wdata;
   logic [3:0]       r_mem_be;
   logic [CNT_W-1:0] r_cnt;

   logic w_busy;
   logic w_any_req;
   logic w_grant_d;
   logic w_timeout;
   logic w_done;

   assign w_busy    = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
   assign w_any_req = instr_req || data_req;
   // A response in the timeout cycle wins over the watchdog.
   assign w_timeout = (TimeoutCycles != 0) && w_busy && !mem_valid &&
                      (r_cnt == CNT_W'(TimeoutCycles));
   assign w_done    = w_busy && (mem_valid || w_timeout);

`ifdef MEM_ARBITER_RR_EN
   logic r_fav_d;

   assign w_grant_d = data_req && (!instr_req || r_fav_d);

   always_ff @(posedge clk) begin
      if (!res) begin
         r_fav_d <= 1'b1;
      end else if ((r_state == S_IDLE) && w_any_req) begin
         r_fav_d <= !w_grant_d;
      end
   end
`else
   assign w_grant_d = data_req;
`endif

   always_ff @(posedge clk) begin
      if (!res) begin
         r_state     <= S_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state     <= w_grant_d ? S_BUSY_D : S_BUSY_I;
                  r_mem_req   <= 1'b1;
                  r_mem_addr  <= w_grant_d ? data_addr : instr_addr;
                  r_mem_we    <= w_grant_d && data_write_enable;
                  r_mem_wdata <= w_grant_d ? data_write : 32'h0;
                  r_mem_be    <= w_grant_d ? data_be : 4'hF;
                  r_cnt       <= '0;
               end
            end
            S_BUSY_I, S_BUSY_D: begin
               if (w_done) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   // Completion is reported combinationally in the cycle the memory (or watchdog) ends it.
   assign instr_valid = (r_state == S_BUSY_I) && (mem_valid || w_timeout);
   assign data_valid  = (r_state == S_BUSY_D) && (mem_valid || w_timeout);
   assign instr_read  = ((r_state == S_BUSY_I) && mem_valid) ? mem_rdata : 32'h0;
   assign data_read   = ((r_state == S_BUSY_D) && mem_valid) ? mem_rdata : 32'h0;
   assign bus_error   = w_timeout;

   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;

endmodule
